// File: rtl/nettlp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nettlp_pkg
// Purpose  : Shared NetTLP definitions. Holds the Eth->PCIe TX FIFO word
//            layout, the header stack length in 64-bit beats and the
//            protocol constants checked while stripping the header stack.
// Revision : 1.0  initial release
// ============================================================================
package nettlp_pkg;

    // Eth 14 B + IPv4 20 B + UDP 8 B + NetTLP 6 B = 48 B = 6 beats of 8 B.
    localparam int NETTLP_HDR_BEATS = 6;

    // Ethernet / IPv4 / UDP constants
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;

    // Eth->PCIe TX FIFO word: {err, tlast, tkeep[7:0], tdata[63:0]}
    typedef struct packed {
        logic        err;
        logic        tlast;
        logic [7:0]  tkeep;
        logic [63:0] tdata;
    } PCIE_FIFO64_TX;

endpackage : nettlp_pkg
`default_nettype wire

// File: rtl/eth_decap_hdr_check.sv
`default_nettype none
// ============================================================================
// Module   : eth_decap_hdr_check
// Purpose  : Combinational per-beat header check. Given the header beat
//            index and the beat data, reports whether the fields carried in
//            that beat are acceptable. Beats with nothing to check pass.
// Ports    : i_beat_cnt  header beat index 0..5
//            i_tdata     beat data, byte 0 in [7:0], network order
//            i_srcmac    adapter MAC (destination MAC check)
//            i_srcip     adapter IP (destination IP check)
//            i_srcport   adapter UDP port (destination port check)
//            o_beat_ok   1 when every field in this beat passes
// Revision : 1.0  initial release
// ============================================================================
module eth_decap_hdr_check
    import nettlp_pkg::*;
#(
    parameter int          CHECK_DSTMAC = 1,
    parameter logic [15:0] DPORT_MASK   = 16'hFC00
) (
    input  logic [2:0]  i_beat_cnt,
    input  logic [63:0] i_tdata,
    input  logic [47:0] i_srcmac,
    input  logic [31:0] i_srcip,
    input  logic [15:0] i_srcport,
    output logic        o_beat_ok
);

    // Split the beat into wire-order bytes; w_byte[0] arrived first.
    logic [7:0] w_byte [8];

    for (genvar i = 0; i < 8; i++) begin : g_byte
        assign w_byte[i] = i_tdata[i*8 +: 8];
    end

    logic [47:0] w_dstmac;
    logic [15:0] w_ethertype;
    logic [15:0] w_ip_hi;
    logic [15:0] w_ip_lo;
    logic [15:0] w_dport;
    logic        w_mac_ok;
    logic        w_port_ok;

    // Multi-byte fields are big-endian on the wire: the earlier byte is MSB.
    assign w_dstmac    = {w_byte[0], w_byte[1], w_byte[2],
                          w_byte[3], w_byte[4], w_byte[5]};
    assign w_ethertype = {w_byte[4], w_byte[5]};
    assign w_ip_hi     = {w_byte[6], w_byte[7]};
    assign w_ip_lo     = {w_byte[0], w_byte[1]};
    assign w_dport     = {w_byte[4], w_byte[5]};

    assign w_mac_ok  = (CHECK_DSTMAC == 0) || (w_dstmac == i_srcmac);
    // Only the masked bits of the port select this adapter; the low bits
    // are free for the host to spread traffic across queues.
    assign w_port_ok = ((w_dport ^ i_srcport) & DPORT_MASK) == 16'h0000;

    always_comb begin
        o_beat_ok = 1'b1;
        case (i_beat_cnt)
            3'd0: o_beat_ok = w_mac_ok;
            3'd1: o_beat_ok = (w_ethertype == ETHERTYPE_IPV4) &&
                              (w_byte[6] == IPV4_VER_IHL);
            3'd2: o_beat_ok = (w_byte[7] == IP_PROTO_UDP);
            3'd3: o_beat_ok = (w_ip_hi == i_srcip[31:16]);
            3'd4: o_beat_ok = (w_ip_lo == i_srcip[15:0]) && w_port_ok;
            default: o_beat_ok = 1'b1;
        endcase
    end

endmodule : eth_decap_hdr_check
`default_nettype wire

// File: rtl/eth_decap_core.sv
`default_nettype none
// ============================================================================
// Module   : eth_decap_core
// Purpose  : Receive-side NetTLP decapsulator. Validates the Ethernet, IPv4,
//            UDP and NetTLP headers of frames from the MAC RX stream, strips
//            the 6-beat header stack and writes the remaining TLP beats into
//            the Eth->PCIe TX FIFO. Frames failing any check are discarded
//            before any FIFO write.
// Ports    : eth_clk / eth_rst_n      clock, synchronous active-low reset
//            eth_rx_*                 MAC RX AXI-Stream (tvalid/tready/tdata/
//                                     tkeep/tlast/tuser)
//            adapter_reg_src*         adapter MAC / IP / UDP port
//            wr_en / din / full       TX FIFO write side
//            stat_rx_frames/drops     accepted / dropped frame counters
// Config   : ETH_DECAP_STATS_EN  defined   -> statistics counters present
//                                undefined -> statistics outputs tied to 0
// Revision : 1.0  initial release
// ============================================================================
module eth_decap_core
    import nettlp_pkg::*;
#(
    parameter int          CHECK_DSTMAC = 1,
    parameter logic [15:0] DPORT_MASK   = 16'hFC00
) (
    input  logic          eth_clk,
    input  logic          eth_rst_n,
    input  logic          eth_rx_tvalid,
    output logic          eth_rx_tready,
    input  logic [63:0]   eth_rx_tdata,
    input  logic [7:0]    eth_rx_tkeep,
    input  logic          eth_rx_tlast,
    input  logic          eth_rx_tuser,
    input  logic [47:0]   adapter_reg_srcmac,
    input  logic [31:0]   adapter_reg_srcip,
    input  logic [15:0]   adapter_reg_srcport,
    output logic          wr_en,
    output PCIE_FIFO64_TX din,
    input  logic          full,
    output logic [31:0]   stat_rx_frames,
    output logic [31:0]   stat_rx_drops
);

    localparam logic [1:0] c_st_hdr     = 2'd0;
    localparam logic [1:0] c_st_payload = 2'd1;
    localparam logic [1:0] c_st_drop    = 2'd2;

    localparam logic [2:0] c_last_hdr_beat = 3'(NETTLP_HDR_BEATS - 1);

    logic [1:0]    r_state;
    logic [2:0]    r_beat_cnt;
    logic          r_ok;
    logic          r_out_vld;
    PCIE_FIFO64_TX r_din;

    logic          w_accept;
    logic          w_beat_ok;
    logic          w_hdr_ok;
    logic          w_load;

    // ------------------------------------------------------------------
    // Handshake. The single output register can take a new beat whenever
    // it is empty or is being drained this cycle, so tready only falls
    // while a word is held against a full FIFO.
    // ------------------------------------------------------------------
    assign eth_rx_tready = ~r_out_vld | ~full;
    assign w_accept      = eth_rx_tvalid & eth_rx_tready;
    assign wr_en         = r_out_vld & ~full;
    assign din           = r_din;

    // ------------------------------------------------------------------
    // Header check of the current beat
    // ------------------------------------------------------------------
    eth_decap_hdr_check #(
        .CHECK_DSTMAC (CHECK_DSTMAC),
        .DPORT_MASK   (DPORT_MASK)
    ) u_hdr_check (
        .i_beat_cnt (r_beat_cnt),
        .i_tdata    (eth_rx_tdata),
        .i_srcmac   (adapter_reg_srcmac),
        .i_srcip    (adapter_reg_srcip),
        .i_srcport  (adapter_reg_srcport),
        .o_beat_ok  (w_beat_ok)
    );

    // Running verdict including the current beat. H0 starts a fresh
    // verdict so a stale result from the previous frame never leaks in.
    assign w_hdr_ok = (r_beat_cnt == 3'd0) ? w_beat_ok : (r_ok & w_beat_ok);

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    always_ff @(posedge eth_clk) begin
        if (!eth_rst_n) begin
            r_state    <= c_st_hdr;
            r_beat_cnt <= 3'd0;
            r_ok       <= 1'b0;
        end else if (w_accept) begin
            case (r_state)
                c_st_hdr: begin
                    r_ok <= w_hdr_ok;
                    if (eth_rx_tlast) begin
                        // Runt: frame ended inside the header stack, even
                        // if it ended exactly on H5. Stay in HDR.
                        r_beat_cnt <= 3'd0;
                    end else if (r_beat_cnt == c_last_hdr_beat) begin
                        r_beat_cnt <= 3'd0;
                        r_state    <= w_hdr_ok ? c_st_payload : c_st_drop;
                    end else begin
                        r_beat_cnt <= r_beat_cnt + 3'd1;
                    end
                end
                c_st_payload, c_st_drop: begin
                    if (eth_rx_tlast) begin
                        r_state <= c_st_hdr;
                    end
                end
                default: begin
                    r_state    <= c_st_hdr;
                    r_beat_cnt <= 3'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output register. A payload beat always loads; otherwise a completed
    // write empties the register. The frame error flag is only meaningful
    // on the tlast word.
    // ------------------------------------------------------------------
    assign w_load = w_accept & (r_state == c_st_payload);

    always_ff @(posedge eth_clk) begin
        if (!eth_rst_n) begin
            r_out_vld <= 1'b0;
            r_din     <= '0;
        end else if (w_load) begin
            r_out_vld   <= 1'b1;
            r_din.err   <= eth_rx_tuser & eth_rx_tlast;
            r_din.tlast <= eth_rx_tlast;
            r_din.tkeep <= eth_rx_tkeep;
            r_din.tdata <= eth_rx_tdata;
        end else if (wr_en) begin
            r_out_vld <= 1'b0;
            r_din     <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Statistics. Errored frames still count as accepted; the downstream
    // consumer discards them using the err flag. Counters wrap freely.
    // ------------------------------------------------------------------
`ifdef ETH_DECAP_STATS_EN
    logic        w_frame_done;
    logic        w_frame_drop;
    logic [31:0] r_stat_frames;
    logic [31:0] r_stat_drops;

    assign w_frame_done = w_accept & eth_rx_tlast & (r_state == c_st_payload);
    assign w_frame_drop = w_accept & eth_rx_tlast & (r_state != c_st_payload);

    always_ff @(posedge eth_clk) begin
        if (!eth_rst_n) begin
            r_stat_frames <= 32'd0;
            r_stat_drops  <= 32'd0;
        end else begin
            if (w_frame_done) begin
                r_stat_frames <= r_stat_frames + 32'd1;
            end
            if (w_frame_drop) begin
                r_stat_drops <= r_stat_drops + 32'd1;
            end
        end
    end

    assign stat_rx_frames = r_stat_frames;
    assign stat_rx_drops  = r_stat_drops;
`else
    assign stat_rx_frames = 32'd0;
    assign stat_rx_drops  = 32'd0;
`endif

endmodule : eth_decap_core
`default_nettype wire

// File: tb/tb_eth_decap_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_decap_core
// Purpose  : Self-checking bench for eth_decap_core. A table of frame
//            records (header fields, payload shape, expected writes and
//            frame/drop outcome) is applied in a loop; hand-written
//            sequences cover FIFO backpressure and reset mid-payload.
// Revision : 1.0  initial release
// ============================================================================
module tb_eth_decap_core;
    import nettlp_pkg::*;

    localparam logic [47:0] MAC_OK  = 48'h00BB00BB00BB;
    localparam logic [31:0] IP_OK   = 32'hC0A80B7A;   // 192.168.11.122
    localparam logic [15:0] PORT_OK = 16'hC351;

`ifdef ETH_DECAP_STATS_EN
    localparam logic [31:0] STAT_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] STAT_MASK = 32'h0000_0000;
`endif

    logic          eth_clk = 1'b0;
    logic          eth_rst_n = 1'b0;
    logic          eth_rx_tvalid = 1'b0;
    logic          eth_rx_tready;
    logic [63:0]   eth_rx_tdata = '0;
    logic [7:0]    eth_rx_tkeep = '0;
    logic          eth_rx_tlast = 1'b0;
    logic          eth_rx_tuser = 1'b0;
    logic          wr_en;
    PCIE_FIFO64_TX din;
    logic          full = 1'b0;
    logic [31:0]   stat_rx_frames;
    logic [31:0]   stat_rx_drops;

    always #5 eth_clk = ~eth_clk;

    eth_decap_core dut (
        .eth_clk             (eth_clk),
        .eth_rst_n           (eth_rst_n),
        .eth_rx_tvalid       (eth_rx_tvalid),
        .eth_rx_tready       (eth_rx_tready),
        .eth_rx_tdata        (eth_rx_tdata),
        .eth_rx_tkeep        (eth_rx_tkeep),
        .eth_rx_tlast        (eth_rx_tlast),
        .eth_rx_tuser        (eth_rx_tuser),
        .adapter_reg_srcmac  (MAC_OK),
        .adapter_reg_srcip   (IP_OK),
        .adapter_reg_srcport (PORT_OK),
        .wr_en               (wr_en),
        .din                 (din),
        .full                (full),
        .stat_rx_frames      (stat_rx_frames),
        .stat_rx_drops       (stat_rx_drops)
    );

    typedef struct {
        logic [47:0] mac;
        logic [15:0] etype;
        logic [7:0]  verihl;
        logic [7:0]  proto;
        logic [31:0] ip;
        logic [15:0] dport;
        int          npay;       // payload beats
        logic [7:0]  last_keep;
        logic        tuser;
        int          runt_at;    // -1: full frame, else header beat carrying tlast
        bit          b2b;        // next frame follows with no idle cycle
        int          exp_writes;
        int          exp_frames;
        int          exp_drops;
    } vec_t;

    vec_t vecs [12];

    int total = 0;
    int bad = 0;
    int wr_count = 0;
    int seed = 0;
    int m_writes = 0;
    int m_frames = 0;
    int m_drops = 0;

    logic [63:0]   fr_data [$];
    logic [7:0]    fr_keep [$];
    logic          fr_last [$];
    logic          fr_user [$];
    PCIE_FIFO64_TX exp_q   [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_stat(input int n);
        return 32'(n) & STAT_MASK;
    endfunction

    function automatic vec_t mk(input logic [47:0] mac, input logic [15:0] et,
                                input logic [7:0] vi, input logic [7:0] pr,
                                input logic [31:0] ip, input logic [15:0] dp,
                                input int npay, input logic [7:0] lk, input logic tu,
                                input int runt, input bit b2b,
                                input int ew, input int ef, input int ed);
        vec_t v;
        v.mac = mac; v.etype = et; v.verihl = vi; v.proto = pr; v.ip = ip; v.dport = dp;
        v.npay = npay; v.last_keep = lk; v.tuser = tu; v.runt_at = runt; v.b2b = b2b;
        v.exp_writes = ew; v.exp_frames = ef; v.exp_drops = ed;
        return v;
    endfunction

    // Builds the beat queues for one frame; expected FIFO words are queued
    // only for frames the table marks as accepted.
    task automatic build_frame(input vec_t v);
        logic [7:0]    hb [48];
        logic [63:0]   d;
        PCIE_FIFO64_TX w;
        int            nb;
        fr_data.delete(); fr_keep.delete(); fr_last.delete(); fr_user.delete();
        for (int j = 0; j < 48; j++) hb[j] = 8'h00;
        for (int k = 0; k < 6; k++) hb[k] = v.mac[47-8*k -: 8];
        hb[6] = 8'h02; hb[11] = 8'h01;
        hb[12] = v.etype[15:8]; hb[13] = v.etype[7:0];
        hb[14] = v.verihl; hb[17] = 8'h4A; hb[22] = 8'h40; hb[23] = v.proto;
        hb[26] = 8'hC0; hb[27] = 8'hA8; hb[28] = 8'h0B; hb[29] = 8'h01;
        for (int k = 0; k < 4; k++) hb[30+k] = v.ip[31-8*k -: 8];
        hb[34] = 8'h30; hb[35] = 8'h00;
        hb[36] = v.dport[15:8]; hb[37] = v.dport[7:0];
        hb[43] = 8'h01; hb[47] = 8'h5A;
        nb = (v.runt_at >= 0) ? v.runt_at + 1 : 6;
        for (int k = 0; k < nb; k++) begin
            for (int j = 0; j < 8; j++) d[j*8 +: 8] = hb[8*k+j];
            fr_data.push_back(d);
            fr_keep.push_back(8'hFF);
            fr_last.push_back(v.runt_at >= 0 && k == v.runt_at);
            fr_user.push_back(1'b0);
        end
        if (v.runt_at < 0) begin
            for (int p = 0; p < v.npay; p++) begin
                for (int j = 0; j < 8; j++) begin
                    d[j*8 +: 8] = 8'(seed);
                    seed++;
                end
                w.tdata = d;
                w.tlast = (p == v.npay - 1);
                w.tkeep = w.tlast ? v.last_keep : 8'hFF;
                w.err   = w.tlast ? v.tuser : 1'b0;
                fr_data.push_back(d);
                fr_keep.push_back(w.tkeep);
                fr_last.push_back(w.tlast);
                fr_user.push_back(w.err);
                if (v.exp_frames != 0) exp_q.push_back(w);
            end
        end
    endtask

    // Drives the queued frame; returns after the last beat has been seen
    // with tready high, i.e. it is taken on the coming rising edge.
    task automatic send_frame(output int lows);
        int budget;
        lows = 0;
        for (int i = 0; i < fr_data.size(); i++) begin
            @(negedge eth_clk);
            eth_rx_tvalid = 1'b1;
            eth_rx_tdata  = fr_data[i];
            eth_rx_tkeep  = fr_keep[i];
            eth_rx_tlast  = fr_last[i];
            eth_rx_tuser  = fr_user[i];
            #1;
            budget = 0;
            while (!eth_rx_tready && budget < 100) begin
                lows++;
                @(negedge eth_clk);
                #1;
                budget++;
            end
            if (!eth_rx_tready) begin
                total++;
                bad++;
                $display("FAIL tready_timeout: got tready=0 expected 1 within 100 cycles");
            end
        end
    endtask

    task automatic go_idle();
        @(negedge eth_clk);
        eth_rx_tvalid = 1'b0;
        eth_rx_tlast  = 1'b0;
        eth_rx_tuser  = 1'b0;
        repeat (4) @(negedge eth_clk);
        #3;
    endtask

    task automatic check_totals(input string tag);
        check({tag, "_writes"}, 128'(wr_count), 128'(m_writes));
        check({tag, "_frames"}, 128'(stat_rx_frames), 128'(exp_stat(m_frames)));
        check({tag, "_drops"},  128'(stat_rx_drops),  128'(exp_stat(m_drops)));
    endtask

    // FIFO-side monitor: every write must match the next expected word.
    initial begin
        PCIE_FIFO64_TX exp_w;
        forever begin
            @(negedge eth_clk);
            #2;
            if (wr_en) begin
                wr_count++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got %h expected no write", din);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("wr_word", 128'(din), 128'(exp_w));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lows;
        vec_t vr;
        logic [73:0] held;

        //            mac            etype     vi     pr     ip            dport     np lk     tu  runt b2b  ew ef ed
        vecs[0]  = mk(MAC_OK,        16'h0800, 8'h45, 8'd17, IP_OK,        16'hC351, 2, 8'hFF, 0, -1, 0,   2, 1, 0);
        vecs[1]  = mk(MAC_OK,        16'h0800, 8'h45, 8'd17, 32'hC0A80B7B, 16'hC351, 2, 8'hFF, 0, -1, 0,   0, 0, 1);
        vecs[2]  = mk(MAC_OK,        16'h86DD, 8'h45, 8'd17, IP_OK,        16'hC351, 2, 8'hFF, 0, -1, 0,   0, 0, 1);
        vecs[3]  = mk(48'h00BB00BB00BA, 16'h0800, 8'h45, 8'd17, IP_OK,     16'hC351, 2, 8'hFF, 0, -1, 0,   0, 0, 1);
        vecs[4]  = mk(MAC_OK,        16'h0800, 8'h46, 8'd17, IP_OK,        16'hC351, 2, 8'hFF, 0, -1, 0,   0, 0, 1);
        vecs[5]  = mk(MAC_OK,        16'h0800, 8'h45, 8'd6,  IP_OK,        16'hC351, 2, 8'hFF, 0, -1, 0,   0, 0, 1);
        vecs[6]  = mk(MAC_OK,        16'h0800, 8'h45, 8'd17, IP_OK,        16'hC3FF, 1, 8'hFF, 0, -1, 0,   1, 1, 0);
        vecs[7]  = mk(MAC_OK,        16'h0800, 8'h45, 8'd17, IP_OK,        16'h0351, 2, 8'hFF, 0, -1, 0,   0, 0, 1);
        vecs[8]  = mk(MAC_OK,        16'h0800, 8'h45, 8'd17, IP_OK,        16'hC351, 0, 8'hFF, 0,  3, 1,   0, 0, 1);
        vecs[9]  = mk(MAC_OK,        16'h0800, 8'h45, 8'd17, IP_OK,        16'hC351, 2, 8'hFF, 0, -1, 0,   2, 1, 0);
        vecs[10] = mk(MAC_OK,        16'h0800, 8'h45, 8'd17, IP_OK,        16'hC351, 0, 8'hFF, 0,  5, 1,   0, 0, 1);
        vecs[11] = mk(MAC_OK,        16'h0800, 8'h45, 8'd17, IP_OK,        16'hC351, 3, 8'h0F, 1, -1, 0,   3, 1, 0);

        // Reset state
        repeat (3) @(negedge eth_clk);
        eth_rst_n = 1'b1;
        #3;
        check("rst_tready", 128'(eth_rx_tready), 128'(1));
        check("rst_wr_en",  128'(wr_en), 128'(0));
        check("rst_din",    128'(din), 128'(0));
        check("rst_frames", 128'(stat_rx_frames), 128'(0));
        check("rst_drops",  128'(stat_rx_drops), 128'(0));

        // Table-driven frames
        for (int i = 0; i < 12; i++) begin
            build_frame(vecs[i]);
            send_frame(lows);
            m_writes += vecs[i].exp_writes;
            m_frames += vecs[i].exp_frames;
            m_drops  += vecs[i].exp_drops;
            if (vecs[i].exp_frames == 0)
                check($sformatf("v%0d_tready_low_cycles", i), 128'(lows), 128'(0));
            if (!vecs[i].b2b) begin
                go_idle();
                check_totals($sformatf("v%0d", i));
            end
        end

        // 64 B TLP with the FIFO full for 5 cycles mid-payload
        vr = mk(MAC_OK, 16'h0800, 8'h45, 8'd17, IP_OK, 16'hC351, 8, 8'hFF, 0, -1, 0, 8, 1, 0);
        build_frame(vr);
        fork
            send_frame(lows);
            begin
                int base;
                int n;
                base = wr_count;
                n = 0;
                while (wr_count < base + 3 && n < 200) begin
                    @(negedge eth_clk);
                    n++;
                end
                check("stall_reached", 128'(wr_count >= base + 3), 128'(1));
                full = 1'b1;
                #3;
                held = din;
                for (int k = 0; k < 5; k++) begin
                    check("stall_wr_en",  128'(wr_en), 128'(0));
                    check("stall_tready", 128'(eth_rx_tready), 128'(0));
                    if (k > 0) check("stall_din_held", 128'(din), 128'(held));
                    @(negedge eth_clk);
                    if (k == 4) full = 1'b0;
                    else #3;
                end
            end
        join
        m_writes += vr.exp_writes;
        m_frames += vr.exp_frames;
        go_idle();
        check_totals("stall");

        // Reset asserted for one cycle while a payload word is pending
        vr = mk(MAC_OK, 16'h0800, 8'h45, 8'd17, IP_OK, 16'hC351, 8, 8'hFF, 0, -1, 0, 0, 0, 0);
        build_frame(vr);
        for (int k = 0; k < 9; k++) begin
            PCIE_FIFO64_TX w;
            @(negedge eth_clk);
            eth_rx_tvalid = 1'b1;
            eth_rx_tdata  = fr_data[k];
            eth_rx_tkeep  = fr_keep[k];
            eth_rx_tlast  = fr_last[k];
            eth_rx_tuser  = fr_user[k];
            if (k >= 6) begin
                w.err = 1'b0; w.tlast = 1'b0; w.tkeep = 8'hFF; w.tdata = fr_data[k];
                exp_q.push_back(w);
            end
            if (k == 7) begin
                #3;
                check("latency_wr_en", 128'(wr_en), 128'(1));
                check("latency_data",  128'(din.tdata), 128'(fr_data[6]));
            end
        end
        @(negedge eth_clk);
        eth_rx_tvalid = 1'b0;
        eth_rst_n = 1'b0;
        @(negedge eth_clk);
        eth_rst_n = 1'b1;
        #3;
        m_writes += 3;
        m_frames = 0;
        m_drops  = 0;
        check("mrst_tready", 128'(eth_rx_tready), 128'(1));
        check("mrst_wr_en",  128'(wr_en), 128'(0));
        check("mrst_din",    128'(din), 128'(0));
        check("mrst_frames", 128'(stat_rx_frames), 128'(0));
        check("mrst_drops",  128'(stat_rx_drops), 128'(0));

        vr = mk(MAC_OK, 16'h0800, 8'h45, 8'd17, IP_OK, 16'hC351, 2, 8'hFF, 0, -1, 0, 2, 1, 0);
        build_frame(vr);
        send_frame(lows);
        m_writes += vr.exp_writes;
        m_frames += vr.exp_frames;
        go_idle();
        check_totals("post_rst");

        check("sb_empty", 128'(exp_q.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_eth_decap_core
`default_nettype wire

// File: doc/eth_decap_core.md
# eth_decap_core

Receive-side NetTLP decapsulator. Accepts Ethernet frames from the 10G MAC RX AXI-Stream on `eth_clk` and validates the Ethernet, IPv4, UDP and NetTLP headers. Strips the 48-byte header stack and writes the remaining TLP beats into the Eth→PCIe TX FIFO. The PCIe-side transmitter drains that FIFO. Frames that fail any header check are discarded before any FIFO write.

## Interface
Parameters:
- `CHECK_DSTMAC`, 1: when 1, the frame's destination MAC must equal `adapter_reg_srcmac`; when 0, the MAC check is skipped.
- `DPORT_MASK`, 16'hFC00: the frame passes when `(udp_dport & DPORT_MASK) == (adapter_reg_srcport & DPORT_MASK)`.

Ports:
- `eth_clk` in 1: the only clock.
- `eth_rst_n` in 1: reset, synchronous, active-low.
- `eth_rx_tvalid` in 1: MAC RX beat valid.
- `eth_rx_tready` out 1: MAC RX backpressure.
- `eth_rx_tdata` in 64: MAC RX data; byte 0 of the beat is in [7:0], network order.
- `eth_rx_tkeep` in 8: MAC RX byte enables.
- `eth_rx_tlast` in 1: last beat of the frame.
- `eth_rx_tuser` in 1: frame error (FCS/PHY), sampled on the tlast beat.
- `adapter_reg_srcmac` in 48: adapter's own MAC, used for the destination MAC check.
- `adapter_reg_srcip` in 32: adapter's own IP, used for the destination IP check.
- `adapter_reg_srcport` in 16: adapter's own UDP port, used for the destination port check.
- `wr_en` out 1: TX FIFO write strobe.
- `din` out `PCIE_FIFO64_TX`: FIFO word {err, tlast, tkeep[7:0], tdata[63:0]}.
- `full` in 1: TX FIFO full.
- `stat_rx_frames` out 32: count of accepted frames.
- `stat_rx_drops` out 32: count of dropped frames.

## Operation
- The header occupies exactly 6 beats, H0..H5: Eth 14 B + IPv4 20 B + UDP 8 B + NetTLP 6 B (seq 2 B, tstamp 4 B). The TLP starts 8-byte aligned at beat 6.
- Checks, with the beat/byte where each field sits:
  - Destination MAC: H0 bytes 0-5.
  - Ethertype == 16'h0800: H1 bytes 4-5.
  - Version/IHL == 8'h45: H1 byte 6.
  - Protocol == 8'd17: H2 byte 7.
  - Destination IP == `adapter_reg_srcip`: H3 bytes 6-7 and H4 bytes 0-1.
  - Destination port per `DPORT_MASK`: H4 bytes 4-5.
- An `ok` flag is cleared at H0 and ANDed with each beat's check result. The IP and UDP checksums are not checked.
- FSM states:
  - HDR (beat counter 0..5): advances on each accepted beat. At H5, goes to PAYLOAD if `ok`, else DROP.
  - PAYLOAD: each accepted beat is forwarded. On tlast, increments `stat_rx_frames` and returns to HDR with counter 0.
  - DROP: consumes beats until tlast, increments `stat_rx_drops`, then returns to HDR.
- tlast seen in HDR (runt frame, including tlast exactly on H5): the frame is dropped and counted, and the FSM returns to HDR at counter 0. Nothing is written.
- Output stage is one register (`out_vld`, `din`):
  - `wr_en = out_vld & ~full`.
  - `eth_rx_tready = ~out_vld | ~full`.
  - The register loads on an accepted PAYLOAD beat and clears when written with no new beat arriving.
- `din.err` = `eth_rx_tuser` on the tlast beat, 0 otherwise. Errored frames are still counted in `stat_rx_frames`; the downstream consumer discards them.
- `tkeep` is passed through unchanged.
- A beat is consumed only when `tvalid & tready`. Headers are never written, so no rollback is needed.

## Timing
- Reset values: `eth_rx_tready` = 1, `wr_en` = 0, `din` = 0, `out_vld` = 0, state HDR, counter 0, `ok` = 0, both stats = 0.
- Latency: a PAYLOAD beat accepted in cycle N gives `wr_en` in cycle N+1 when `full` = 0.
- `full` held high stalls `wr_en` and holds `din` stable. `tready` drops only while `out_vld` = 1.
- Back-to-back frames: H0 of the next frame may be accepted the cycle after the previous tlast, with no bubble.
- Reset mid-frame: the remainder of the interrupted frame is parsed as a new header and fails the checks. The MAC guarantees a clean restart.
- Statistics counters wrap at 2^32 with no saturation.

## Configuration
- `ETH_DECAP_STATS_EN` defined: both statistics counters are implemented.
- `ETH_DECAP_STATS_EN` undefined: the counters are removed and `stat_rx_frames` / `stat_rx_drops` are tied to 0. The ports are present in both cases.

## Structure
- Shared package `nettlp_pkg` holds:
  - the `PCIE_FIFO64_TX` struct;
  - `NETTLP_HDR_BEATS = 6`;
  - the ethertype, IP version/IHL and UDP protocol constants (reuse `ethernet_pkg` / `ip_pkg` where they already exist).
- One sub-module, `eth_decap_hdr_check`: combinational check of the current beat given the counter, returning a per-beat pass bit. The FSM and output stage stay in `eth_decap_core`.

## Test plan
- Valid frame: MAC 00:BB:00:BB:00:BB, IP 192.168.11.122, dport 0xC351, 16 B TLP (beats 6-7, tkeep FF/FF) → exactly 2 writes, tlast on the second, `stat_rx_frames` = 1.
- Wrong IP 192.168.11.123 and ethertype 0x86DD, one frame each → zero writes, `stat_rx_drops` = 2, tready stays 1.
- Runt frame: tlast on H3, immediately followed by a valid frame → runt dropped, valid frame forwarded intact.
- `full` held high for 5 cycles mid-payload of a 64 B TLP → no beat lost or duplicated; data order preserved.
- Valid frame with tuser = 1 on tlast → last FIFO word has err = 1 and tkeep = 8'h0F for a 4-byte tail.
- `eth_rst_n` low for 1 cycle mid-PAYLOAD → all outputs return to reset values the next cycle; the next valid frame is forwarded.
